// File: rtl/bus_pkg.sv
// Shared definitions for the system bus decoder/arbiter.
//   - FSM state encodings
//   - default error data and default peripheral address map
//   - idx_w(): width of a slave index for a given slave count
package bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] ERR_DATA_DEF = 32'h0000_0000;

    // Default peripheral windows (slot: base / mask)
    localparam int unsigned DEF_N_SLV = 5;
    localparam logic [31:0] GPU_BASE   = 32'hFFC0_0000;  // 2 KiB window
    localparam logic [31:0] GPU_MASK   = 32'hFFFF_F800;
    localparam logic [31:0] FLASH_BASE = 32'hFFFF_FE00;  // flash data/ctrl register
    localparam logic [31:0] FLASH_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] TIMER_BASE = 32'hFFFF_FE04;
    localparam logic [31:0] TIMER_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] UART_BASE  = 32'hFFFF_FE08;  // FE08 data, FE0C status
    localparam logic [31:0] UART_MASK  = 32'hFFFF_FFF8;
    localparam logic [31:0] PS2_BASE   = 32'hFFFF_FE10;
    localparam logic [31:0] PS2_MASK   = 32'hFFFF_FFFC;

    // Slot 0 occupies the least-significant word
    localparam logic [DEF_N_SLV*32-1:0] DEF_SLV_BASE =
        {PS2_BASE, UART_BASE, TIMER_BASE, FLASH_BASE, GPU_BASE};
    localparam logic [DEF_N_SLV*32-1:0] DEF_SLV_MASK =
        {PS2_MASK, UART_MASK, TIMER_MASK, FLASH_MASK, GPU_MASK};

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: priority-encodes N_SLV base/mask windows.
//   addr : address to decode
//   hit  : some window matches
//   idx  : lowest matching slot index (0 when no hit)
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int unsigned N_SLV = DEF_N_SLV,
    parameter int unsigned AW    = 32,
    parameter int unsigned IW    = idx_w(N_SLV),
    parameter logic [N_SLV*AW-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest matching slot is written last
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_xbar.sv
// Registered single-master bus decoder with per-slave strobes, ack wait,
// timeout abort and a sticky fault record.
//   clk, rst            : clock, synchronous active-high reset
//   m_*                 : master request (level, held until ack) and response
//   s_addr/data/sel_o   : latched request broadcast to every slave
//   s_rd_o / s_we_o     : per-slave registered strobes
//   s_data_i / s_ack_i  : per-slave read data and ack
//   fault_*             : sticky error flag, last error address and cause
module bus_arbiter_xbar
    import bus_pkg::*;
#(
    parameter int unsigned N_SLV   = DEF_N_SLV,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SW      = 2,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLV*AW-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       m_addr_i,
    input  logic [DW-1:0]       m_data_i,
    input  logic [SW-1:0]       m_sel_i,
    input  logic                m_rd_i,
    input  logic                m_we_i,
    output logic [DW-1:0]       m_data_o,
    output logic                m_ack_o,
    output logic                m_err_o,
    output logic [N_SLV*AW-1:0] s_addr_o,
    output logic [N_SLV*DW-1:0] s_data_o,
    output logic [N_SLV*SW-1:0] s_sel_o,
    output logic [N_SLV-1:0]    s_rd_o,
    output logic [N_SLV-1:0]    s_we_o,
    input  logic [N_SLV*DW-1:0] s_data_i,
    input  logic [N_SLV-1:0]    s_ack_i,
    output logic                fault_o,
    output logic [AW-1:0]       fault_addr_o,
    output logic                fault_to_o,
    input  logic                fault_clr_i
);

    localparam int unsigned IW = idx_w(N_SLV);
    // Counter must reach TIMEOUT itself (one strobe-free cycle after abort)
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic             we_q, we_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             to_q, to_d;
    logic [N_SLV-1:0] rd_d, wr_d;
    logic             ack_d, err_d;
    logic [DW-1:0]    rdata_d;
    logic             fault_d, fto_d;
    logic [AW-1:0]    faddr_d;

    logic             dec_hit;
    logic [IW-1:0]    dec_idx;
    logic [N_SLV-1:0] dec_oh;
    logic             sel_ack;
    logic [DW-1:0]    sel_rdata;
    logic             strobe_on;

    bus_addr_decoder #(
        .N_SLV    (N_SLV),
        .AW       (AW),
        .IW       (IW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (m_addr_i),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign dec_oh    = N_SLV'(1) << dec_idx;
    assign strobe_on = |(s_rd_o | s_we_o);

    assign s_addr_o = {N_SLV{addr_q}};
    assign s_data_o = {N_SLV{data_q}};
    assign s_sel_o  = {N_SLV{sel_q}};

    // Only the selected slave's ack and data are visible to the FSM
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (idx_q == IW'(i)) begin
                sel_ack   = s_ack_i[i];
                sel_rdata = s_data_i[i*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        we_d    = we_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        rd_d    = s_rd_o;
        wr_d    = s_we_o;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = m_data_o;
        faddr_d = fault_addr_o;
        fto_d   = fault_to_o;
        // Clear first so a same-cycle fault set below overrides it
        fault_d = fault_clr_i ? 1'b0 : fault_o;

        case (state_q)
            ST_IDLE: begin
                if (m_rd_i || m_we_i) begin
                    addr_d = m_addr_i;
                    data_d = m_data_i;
                    sel_d  = m_sel_i;
                    we_d   = m_we_i;
                    idx_d  = dec_idx;
                    cnt_d  = '0;
                    to_d   = 1'b0;
                    if (dec_hit) begin
                        state_d = ST_REQ;
                        if (m_we_i) begin
                            wr_d = dec_oh;
                        end else begin
                            rd_d = dec_oh;
                        end
                    end else begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end
                end
            end
            ST_REQ: begin
                if (strobe_on && sel_ack) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    rdata_d = we_q ? ERR_DATA : sel_rdata;
                    rd_d    = '0;
                    wr_d    = '0;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    // Last strobe cycle without ack: drop strobe, respond next cycle
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rd_d = '0;
                        wr_d = '0;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (m_err_o) begin
                    fault_d = 1'b1;
                    faddr_d = addr_q;
                    fto_d   = to_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = '0;
                wr_d    = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            to_q         <= 1'b0;
            s_rd_o       <= '0;
            s_we_o       <= '0;
            m_ack_o      <= 1'b0;
            m_err_o      <= 1'b0;
            m_data_o     <= '0;
            fault_o      <= 1'b0;
            fault_addr_o <= '0;
            fault_to_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            to_q         <= to_d;
            s_rd_o       <= rd_d;
            s_we_o       <= wr_d;
            m_ack_o      <= ack_d;
            m_err_o      <= err_d;
            m_data_o     <= rdata_d;
            fault_o      <= fault_d;
            fault_addr_o <= faddr_d;
            fault_to_o   <= fto_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_xbar.sv
// Directed, table-driven bench for bus_arbiter_xbar (TIMEOUT=4, custom map
// with overlapping windows on slots 1 and 3).
module tb_bus_arbiter_xbar;

    localparam int N  = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 2;

    localparam logic [N*AW-1:0] TB_BASE =
        {32'hFFFF_FE10, 32'h8000_0000, 32'hFFFF_FE04, 32'h8000_0000, 32'hFFC0_0000};
    localparam logic [N*AW-1:0] TB_MASK =
        {32'hFFFF_FFFC, 32'hFFFF_0000, 32'hFFFF_FFFC, 32'hF000_0000, 32'hFFFF_F800};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic [SW-1:0]   m_sel = '0;
    logic            m_rd = 1'b0;
    logic            m_we = 1'b0;
    logic [DW-1:0]   m_rdata;
    logic            m_ack;
    logic            m_err;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [N*SW-1:0] s_sel;
    logic [N-1:0]    s_rd;
    logic [N-1:0]    s_we;
    logic [N*DW-1:0] s_rdata;
    logic [N-1:0]    s_ack;
    logic            fault;
    logic [AW-1:0]   fault_addr;
    logic            fault_to;
    logic            fault_clr = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_xbar #(
        .N_SLV    (N),
        .AW       (AW),
        .DW       (DW),
        .SW       (SW),
        .SLV_BASE (TB_BASE),
        .SLV_MASK (TB_MASK),
        .TIMEOUT  (4),
        .ERR_DATA (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_addr_i     (m_addr),
        .m_data_i     (m_wdata),
        .m_sel_i      (m_sel),
        .m_rd_i       (m_rd),
        .m_we_i       (m_we),
        .m_data_o     (m_rdata),
        .m_ack_o      (m_ack),
        .m_err_o      (m_err),
        .s_addr_o     (s_addr),
        .s_data_o     (s_wdata),
        .s_sel_o      (s_sel),
        .s_rd_o       (s_rd),
        .s_we_o       (s_we),
        .s_data_i     (s_rdata),
        .s_ack_i      (s_ack),
        .fault_o      (fault),
        .fault_addr_o (fault_addr),
        .fault_to_o   (fault_to),
        .fault_clr_i  (fault_clr)
    );

    // Slave models: fixed read data, combinational ack after wait_tb strobe cycles
    int          wait_tb [N];
    int          scnt [N];
    logic [N-1:0] ack_force = '0;

    assign s_rdata = {32'h0000_00AB, 32'h3333_3333, 32'h1234_5678, 32'hCAFE_0001, 32'hDEAD_0000};

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            scnt[i] <= (s_rd[i] || s_we[i]) ? scnt[i] + 1 : 0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_ack[i] = ((s_rd[i] || s_we[i]) && (scnt[i] == wait_tb[i])) || ack_force[i];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        we;
        int          slv;
        int          wt;
        logic [4:0]  frc;
        logic        hit;
        logic        ewe;
        int          stb;
        int          lat;
        logic        err;
        logic [31:0] data;
        logic        to;
    } vec_t;

    vec_t vecs [8];

    // Called at a negedge; leaves at a negedge in IDLE with the request dropped
    task automatic run_vec(input vec_t v, input int k);
        int         lat;
        int         nstb;
        logic       bad;
        logic       err_s;
        logic [31:0] dat_s;
        logic [N-1:0] em;
        wait_tb[v.slv] = v.wt;
        ack_force = v.frc;
        m_addr  = v.addr;
        m_wdata = v.wdata;
        m_rd    = v.rd;
        m_we    = v.we;
        lat = 0; nstb = 0; bad = 1'b0; err_s = 1'b0; dat_s = '0;
        em = v.hit ? (N'(1) << v.slv) : '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((s_rd | s_we) != '0) begin
                nstb++;
                if (v.ewe ? (s_we != em || s_rd != '0) : (s_rd != em || s_we != '0)) bad = 1'b1;
                if (v.ewe && s_wdata[v.slv*DW +: DW] !== v.wdata) bad = 1'b1;
            end
            if (m_ack) begin
                lat = c; err_s = m_err; dat_s = m_rdata;
                break;
            end
        end
        m_rd = 1'b0; m_we = 1'b0; ack_force = '0;
        chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_err", k), 32'(err_s), 32'(v.err));
        chk($sformatf("v%0d_data", k), dat_s, v.data);
        chk($sformatf("v%0d_strobe_cycles", k), 32'(nstb), 32'(v.stb));
        chk($sformatf("v%0d_wrong_strobe", k), 32'(bad), 32'(0));
        @(negedge clk);
        chk($sformatf("v%0d_ack_pulse", k), 32'(m_ack), 32'(0));
        if (v.err) begin
            chk($sformatf("v%0d_fault", k), 32'(fault), 32'(1));
            chk($sformatf("v%0d_fault_addr", k), fault_addr, v.addr);
            chk($sformatf("v%0d_fault_to", k), 32'(fault_to), 32'(v.to));
        end
    endtask

    initial begin
        logic saw;
        for (int i = 0; i < N; i++) wait_tb[i] = 99;

        //            addr          wdata         rd    we    slv wt frc     hit   ewe stb lat err   data          to
        vecs[0] = '{32'hFFFF_FE04, 32'h0,       1'b1, 1'b0, 2, 0,  5'b0,   1'b1, 1'b0, 1, 2, 1'b0, 32'h1234_5678, 1'b0};
        vecs[1] = '{32'hFFFF_FE10, 32'hA5,      1'b0, 1'b1, 4, 3,  5'b0,   1'b1, 1'b1, 4, 5, 1'b0, 32'h0,         1'b0};
        vecs[2] = '{32'h0000_1000, 32'h0,       1'b1, 1'b0, 0, 0,  5'b0,   1'b0, 1'b0, 0, 1, 1'b1, 32'h0,         1'b0};
        vecs[3] = '{32'hFFC0_0100, 32'h0,       1'b1, 1'b0, 0, 99, 5'b0,   1'b1, 1'b0, 4, 6, 1'b1, 32'h0,         1'b1};
        vecs[4] = '{32'h8000_0010, 32'h5A5A,    1'b1, 1'b1, 1, 1,  5'b0,   1'b1, 1'b1, 2, 3, 1'b0, 32'h0,         1'b0};
        vecs[5] = '{32'h8000_0020, 32'h0,       1'b1, 1'b0, 1, 2,  5'b01001, 1'b1, 1'b0, 3, 4, 1'b0, 32'hCAFE_0001, 1'b0};
        vecs[6] = '{32'hFFFF_FE12, 32'h0,       1'b1, 1'b0, 4, 0,  5'b0,   1'b1, 1'b0, 1, 2, 1'b0, 32'h0000_00AB, 1'b0};
        vecs[7] = '{32'hFFFF_FE20, 32'h77,      1'b0, 1'b1, 0, 0,  5'b0,   1'b0, 1'b0, 0, 1, 1'b1, 32'h0,         1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(m_ack), 32'(0));
        chk("rst_err", 32'(m_err), 32'(0));
        chk("rst_data", m_rdata, 32'h0);
        chk("rst_strobes", 32'({s_rd, s_we}), 32'(0));
        chk("rst_s_bus", 32'((s_addr != '0) || (s_wdata != '0) || (s_sel != '0)), 32'(0));
        chk("rst_fault", 32'({fault, fault_to}), 32'(0));
        chk("rst_fault_addr", fault_addr, 32'h0);

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Clear after an error record
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("fault_clear", 32'(fault), 32'(0));

        // Set and clear in the same cycle: set wins
        m_addr = 32'h0000_2000; m_rd = 1'b1;
        @(negedge clk);
        chk("collide_ack", 32'({m_ack, m_err}), 32'(3));
        m_rd = 1'b0; fault_clr = 1'b1;
        @(negedge clk);
        chk("collide_set_wins", 32'(fault), 32'(1));
        chk("collide_addr", fault_addr, 32'h0000_2000);
        @(negedge clk);
        fault_clr = 1'b0;
        chk("collide_then_clear", 32'(fault), 32'(0));

        // Reset in the second REQ cycle aborts the transfer
        wait_tb[2] = 99;
        m_addr = 32'hFFFF_FE04; m_rd = 1'b1;
        @(negedge clk);
        chk("abort_first_req_strobe", 32'(s_rd), 32'(5'b00100));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strobes_low", 32'({s_rd, s_we}), 32'(0));
        rst = 1'b0; m_rd = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_ack) saw = 1'b1;
        end
        chk("abort_no_ack", 32'(saw), 32'(0));

        // Fresh request after abort
        run_vec(vecs[0], 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
